// File: rtl/data_mem_responder.sv
// Responder for the core's data_sram port: zero-latency word RAM plus an MMIO window
// (LED, timer, scratch, sticky W1C status, RAM write counter).
module data_mem_responder #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        err
);
    localparam int RAM_DEPTH = 1 << RAM_AW;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_TIMER   = 16'h0004;
    localparam logic [15:0] OFF_SCRATCH = 16'h0008;
    localparam logic [15:0] OFF_STATUS  = 16'h000C;
    localparam logic [15:0] OFF_WRCOUNT = 16'h0010;

    logic [31:0] ram_q [0:RAM_DEPTH-1];

    logic [15:0] led_q,      led_d;
    logic [31:0] timer_q,    timer_d;
    logic [31:0] scratch_q,  scratch_d;
    logic [1:0]  status_q,   status_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        err_q,      err_d;

    logic              mmio_hit;
    logic              ram_hit;
    logic              misalign;
    logic [15:0]       offset;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_wr;
    logic              mmio_wr;
    logic [1:0]        status_set;
    logic [1:0]        status_clr;

    // MMIO takes priority should the two windows ever be configured to overlap.
    assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign ram_hit  = (data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]) && !mmio_hit;
    assign misalign = (data_sram_addr[1:0] != 2'b00);
    assign offset   = {data_sram_addr[15:2], 2'b00};
    assign ram_idx  = data_sram_addr[RAM_AW+1:2];

    assign ram_wr  = data_sram_we && !misalign && ram_hit;
    assign mmio_wr = data_sram_we && !misalign && mmio_hit;

    // A misaligned write only reports misalign, even when it is also unmapped.
    assign status_set[1] = data_sram_we && misalign;
    assign status_set[0] = data_sram_we && !misalign && !mmio_hit && !ram_hit;
    assign status_clr    = (mmio_wr && offset == OFF_STATUS) ? data_sram_wdata[1:0] : 2'b00;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_status
            assign status_d[gi] = status_set[gi] | (status_q[gi] & ~status_clr[gi]);
        end
    endgenerate

    always_comb begin
        led_d      = led_q;
        scratch_d  = scratch_q;
        timer_d    = timer_q + 32'd1;
        wr_count_d = wr_count_q;
        err_d      = |status_d;
        if (mmio_wr) begin
            case (offset)
                OFF_LED:     led_d     = data_sram_wdata[15:0];
                OFF_TIMER:   timer_d   = data_sram_wdata;
                OFF_SCRATCH: scratch_d = data_sram_wdata;
                default:     ;
            endcase
        end
        if (ram_wr) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= 16'h0;
            timer_q    <= 32'h0;
            scratch_q  <= 32'h0;
            status_q   <= 2'b00;
            wr_count_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            timer_q    <= timer_d;
            scratch_q  <= scratch_d;
            status_q   <= status_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && ram_wr) begin
            ram_q[ram_idx] <= data_sram_wdata;
        end
    end

    always_comb begin
        data_sram_rdata = 32'h0;
        if (mmio_hit) begin
            case (offset)
                OFF_LED:     data_sram_rdata = {16'h0, led_q};
                OFF_TIMER:   data_sram_rdata = timer_q;
                OFF_SCRATCH: data_sram_rdata = scratch_q;
                OFF_STATUS:  data_sram_rdata = {30'h0, status_q};
                OFF_WRCOUNT: data_sram_rdata = wr_count_q;
                default:     data_sram_rdata = 32'h0;
            endcase
        end else if (ram_hit) begin
            data_sram_rdata = ram_q[ram_idx];
        end
    end

    assign led = led_q;
    assign err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, read-during-write, MMIO registers,
// sticky status with W1C, timer wrap and mid-stream reset.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational read of an address without advancing the clock.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        tick();
        tick();
        // Write during reset must be ignored.
        write(32'hbfaf_0008, 32'h0000_00AA);
        tick();
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        peek("rst_timer",   32'hbfaf_0004, 32'h0);
        peek("rst_scratch", 32'hbfaf_0008, 32'h0);
        peek("rst_status",  32'hbfaf_000C, 32'h0);
        peek("rst_wrcount", 32'hbfaf_0010, 32'h0);

        // Timer: five idle edges after reset release.
        reset = 1'b0;
        addr  = 32'hbfaf_0004;
        repeat (5) tick();
        check("timer_5", rdata, 32'd5);
        write(32'hbfaf_0004, 32'hFFFF_FFFF);
        check("timer_load", rdata, 32'hFFFF_FFFF);
        tick();
        check("timer_wrap", rdata, 32'h0);

        // RAM write then read back.
        write(32'h1c00_0010, 32'hDEAD_BEEF);
        check("ram_rd", rdata, 32'hDEAD_BEEF);
        peek("wrcount_1", 32'hbfaf_0010, 32'd1);
        write(32'h1c00_0000, 32'h0000_0055);

        // Read-during-write returns the old word.
        write(32'h1c00_0010, 32'h0000_0011);
        we    = 1'b1;
        wdata = 32'h0000_0022;
        #1;
        check("rdw_old", rdata, 32'h0000_0011);
        tick();
        we = 1'b0;
        #1;
        check("rdw_new", rdata, 32'h0000_0022);
        peek("wrcount_4", 32'hbfaf_0010, 32'd4);

        // MMIO registers.
        write(32'hbfaf_0000, 32'h0001_2345);
        check("led_out", {16'h0, led}, 32'h0000_2345);
        check("led_rd", rdata, 32'h0000_2345);
        write(32'hbfaf_0010, 32'h0000_0005);
        peek("wrcount_ro", 32'hbfaf_0010, 32'd4);
        write(32'hbfaf_0008, 32'hCAFE_F00D);
        peek("scratch", 32'hbfaf_0008, 32'hCAFE_F00D);
        write(32'hbfaf_0020, 32'h1234_5678);
        peek("mmio_hole", 32'hbfaf_0020, 32'h0);
        peek("status_clean", 32'hbfaf_000C, 32'h0);
        check("err_clean", {31'h0, err}, 32'h0);

        // Unmapped and misaligned writes.
        write(32'h0000_0000, 32'h0000_0077);
        peek("unmapped_rd", 32'h0000_0000, 32'h0);
        peek("status_unm", 32'hbfaf_000C, 32'h1);
        check("err_unm", {31'h0, err}, 32'h1);
        write(32'h1c00_0002, 32'h0000_0099);
        peek("ram_unchanged", 32'h1c00_0000, 32'h0000_0055);
        peek("status_both", 32'hbfaf_000C, 32'h3);
        peek("wrcount_drop", 32'hbfaf_0010, 32'd4);

        // W1C clears, and a misaligned STATUS write only sets misalign.
        write(32'hbfaf_000C, 32'h0000_0001);
        peek("status_w1c", 32'hbfaf_000C, 32'h2);
        check("err_w1c", {31'h0, err}, 32'h1);
        write(32'hbfaf_000C, 32'h0000_0002);
        peek("status_clr", 32'hbfaf_000C, 32'h0);
        check("err_clr", {31'h0, err}, 32'h0);
        write(32'hbfaf_000E, 32'h0000_0003);
        peek("status_mis", 32'hbfaf_000C, 32'h2);

        // Reset mid-stream with a pending write.
        reset = 1'b1;
        we    = 1'b1;
        addr  = 32'hbfaf_0008;
        wdata = 32'h0000_1234;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        #1;
        peek("rst2_scratch", 32'hbfaf_0008, 32'h0);
        check("rst2_led", {16'h0, led}, 32'h0);
        check("rst2_err", {31'h0, err}, 32'h0);
        peek("rst2_status", 32'hbfaf_000C, 32'h0);
        peek("rst2_wrcount", 32'hbfaf_0010, 32'h0);
        peek("rst2_ram", 32'h1c00_0010, 32'h0000_0022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
